// File: rtl/io_ports_pkg.sv
// rtl/io_ports_pkg.sv - register offsets and field widths for the io_ports peripheral
package io_ports_pkg;

    localparam logic [1:0] IO_OFS_LED  = 2'd0;
    localparam logic [1:0] IO_OFS_SW   = 2'd1;
    localparam logic [1:0] IO_OFS_KEY  = 2'd2;
    localparam logic [1:0] IO_OFS_EDGE = 2'd3;

    localparam int LED_W = 8;
    localparam int SW_W  = 4;
    localparam int KEY_W = 2;

endpackage

// File: rtl/io_ports_if.sv
// rtl/io_ports_if.sv - CPU data bus slice seen by the io_ports register window
interface io_ports_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_we;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_hit;

    modport master (
        output i_addr, i_we, i_wdata,
        input  o_rdata, o_hit
    );

    modport slave (
        input  i_addr, i_we, i_wdata,
        output o_rdata, o_hit
    );
endinterface

// File: rtl/io_ports_key_debounce.sv
// rtl/io_ports_key_debounce.sv - 2-flop synchroniser plus stable-count debouncer for one active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw_n,
    output logic o_state,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          s;
    logic          flip;

    assign s       = ~sync;
    assign flip    = (s != o_state) && (cnt == CNT_MAX);
    assign o_press = flip && s;

    // Synchroniser resets to 1 so an idle (released) key looks released straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            o_state <= 1'b0;
            cnt     <= '0;
        end else begin
            meta <= i_raw_n;
            sync <= meta;
            if (s == o_state) begin
                cnt <= '0;
            end else if (flip) begin
                o_state <= s;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_ports.sv
// rtl/io_ports.sv - memory-mapped LED/switch/key peripheral with debounced press-edge capture
module io_ports
    import io_ports_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'hF000_0000,
    parameter int                    DEBOUNCE_CYCLES = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    io_ports_if.slave        bus,
    input  logic [SW_W-1:0]  i_sw,
    input  logic [KEY_W-1:0] i_key,
    output logic [LED_W-1:0] o_led
);
    logic [LED_W-1:0]      led_q;
    logic [SW_W-1:0]       sw_meta;
    logic [SW_W-1:0]       sw_sync;
    logic [KEY_W-1:0]      key_state;
    logic [KEY_W-1:0]      key_press;
    logic [KEY_W-1:0]      edge_q;
    logic [KEY_W-1:0]      edge_clr;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            ofs;
    logic                  hit;
    logic                  wr;
    logic                  unused_bits;

    assign hit         = bus.i_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign ofs         = bus.i_addr[3:2];
    assign wr          = bus.i_we && hit;
    assign edge_clr    = (wr && ofs == IO_OFS_EDGE) ? bus.i_wdata[KEY_W-1:0] : '0;
    assign unused_bits = ^{bus.i_addr[1:0], bus.i_wdata[DATA_WIDTH-1:LED_W]};

    // LEDs are dark for the whole reset assertion, not just from the first reset edge.
    assign o_led = i_rst ? led_q : '0;

    for (genvar k = 0; k < KEY_W; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_raw_n(i_key[k]),
            .o_state(key_state[k]),
            .o_press(key_press[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            edge_q  <= '0;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
            if (wr && ofs == IO_OFS_LED) begin
                led_q <= bus.i_wdata[LED_W-1:0];
            end
            // A press landing on the same edge as its W1C keeps the bit set.
            edge_q <= (edge_q & ~edge_clr) | key_press;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (ofs)
                IO_OFS_LED:  rdata[LED_W-1:0] = led_q;
                IO_OFS_SW:   rdata[SW_W-1:0]  = sw_sync;
                IO_OFS_KEY:  rdata[KEY_W-1:0] = key_state;
                default:     rdata[KEY_W-1:0] = edge_q;
            endcase
        end
    end

    assign bus.o_rdata = rdata;
    assign bus.o_hit   = hit;
endmodule

// File: tb/tb_io_ports.sv
// tb/tb_io_ports.sv - randomized and directed self-checking bench for io_ports
module tb_io_ports;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'hF000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw  = 4'h0;
    logic [1:0] key = 2'b11;
    logic [7:0] led;

    int n_cmp = 0;
    int n_bad = 0;

    io_ports_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    io_ports #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus),
        .i_sw (sw),
        .i_key(key),
        .o_led(led)
    );

    always #5 clk = ~clk;

    // Reference state: register contents plus a short history of raw inputs seen at clock edges.
    logic [7:0] m_led  = 8'h0;
    logic [1:0] m_edge = 2'b0;
    logic [1:0] m_deb  = 2'b0;
    logic [1:0] k_h1   = 2'b11;
    logic [1:0] k_h2   = 2'b11;
    logic [3:0] s_h1   = 4'h0;
    logic [3:0] s_h2   = 4'h0;
    int         m_run [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!exp_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {24'h0, m_led};
            2'd1:    return {28'h0, s_h2};
            2'd2:    return {30'h0, m_deb};
            default: return {30'h0, m_edge};
        endcase
    endfunction

    // A key is accepted once its inverted, 2-edge-delayed sample has disagreed with the
    // accepted value on D consecutive edges.
    task automatic model_edge();
        logic [1:0] press;
        logic [1:0] clr;
        logic       s;
        if (!rst) begin
            m_led = 8'h0; m_edge = 2'b0; m_deb = 2'b0;
            m_run[0] = 0; m_run[1] = 0;
            k_h1 = 2'b11; k_h2 = 2'b11; s_h1 = 4'h0; s_h2 = 4'h0;
        end else begin
            press = 2'b0;
            for (int n = 0; n < 2; n++) begin
                s = ~k_h2[n];
                if (s != m_deb[n]) begin
                    m_run[n]++;
                    if (m_run[n] == D) begin
                        m_deb[n] = s;
                        m_run[n] = 0;
                        press[n] = s;
                    end
                end else begin
                    m_run[n] = 0;
                end
            end
            clr = 2'b0;
            if (bus.i_we && exp_hit(bus.i_addr)) begin
                if (bus.i_addr[3:2] == 2'd0) m_led = bus.i_wdata[7:0];
                if (bus.i_addr[3:2] == 2'd3) clr = bus.i_wdata[1:0];
            end
            m_edge = (m_edge & ~clr) | press;
            k_h2 = k_h1; k_h1 = key;
            s_h2 = s_h1; s_h1 = sw;
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] a, input logic we, input logic [31:0] wd);
        @(negedge clk);
        rst = r; bus.i_addr = a; bus.i_we = we; bus.i_wdata = wd;
        #1;
        chk("hit", bus.o_hit, exp_hit(a));
        chk("rdata", bus.o_rdata, m_read(a));
        chk("led_pre", led, r ? m_led : 8'h0);
        @(posedge clk);
        model_edge();
        #1;
        chk("led", led, rst ? m_led : 8'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, BASE + 32'h8, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.i_addr = a; bus.i_we = 1'b0;
        #1;
        v = bus.o_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic        r;
        logic [31:0] a;
        bus.i_addr = BASE; bus.i_we = 1'b0; bus.i_wdata = 32'h0;

        // Reset overrides an LED write held during reset.
        repeat (3) cyc(1'b0, BASE, 1'b1, 32'hFF);
        chk("t1_led_rst", led, 8'h0);
        cyc(1'b1, BASE, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(i * 4), v);
            chk("t1_read_rst", v, 32'h0);
        end

        cyc(1'b1, BASE, 1'b1, 32'h1234_56A5);
        chk("t2_led", led, 8'hA5);
        rd(BASE, v);
        chk("t2_readback", v, 32'h0000_00A5);
        cyc(1'b1, BASE + 32'h10, 1'b1, 32'h1234_5611);
        bus.i_addr = BASE + 32'h10;
        #1;
        chk("t2_miss_hit", bus.o_hit, 1'b0);
        chk("t2_miss_rdata", bus.o_rdata, 32'h0);
        chk("t2_led_kept", led, 8'hA5);

        sw = 4'hA;
        cyc(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        rd(BASE + 32'h4, v);
        chk("t3_sw_1clk", v, 32'h0);
        cyc(1'b1, BASE + 32'h4, 1'b0, 32'h0);
        rd(BASE + 32'h4, v);
        chk("t3_sw_2clk", v, 32'hA);

        key = 2'b10;
        idle(5);
        rd(BASE + 32'h8, v);
        chk("t4_key_5clk", v, 32'h0);
        idle(1);
        rd(BASE + 32'h8, v);
        chk("t4_key_6clk", v, 32'h1);
        rd(BASE + 32'hC, v);
        chk("t4_edge", v, 32'h1);
        key = 2'b11;
        idle(8);
        cyc(1'b1, BASE + 32'hC, 1'b1, 32'h3);
        rd(BASE + 32'hC, v);
        chk("t4_edge_clr", v, 32'h0);
        key = 2'b10;
        idle(3);
        key = 2'b11;
        idle(8);
        rd(BASE + 32'h8, v);
        chk("t4_pulse_key", v, 32'h0);
        rd(BASE + 32'hC, v);
        chk("t4_pulse_edge", v, 32'h0);

        key = 2'b10;
        idle(6);
        rd(BASE + 32'hC, v);
        chk("t5_edge_pre", v, 32'h1);
        key = 2'b00;
        idle(5);
        cyc(1'b1, BASE + 32'hC, 1'b1, 32'h3);
        rd(BASE + 32'hC, v);
        chk("t5_race", v, 32'h2);
        rd(BASE + 32'h8, v);
        chk("t5_key", v, 32'h3);
        cyc(1'b1, BASE + 32'hC, 1'b1, 32'h0);
        rd(BASE + 32'hC, v);
        chk("t5_w1c_zero", v, 32'h2);

        key = 2'b11;
        idle(8);
        cyc(1'b1, BASE + 32'hC, 1'b1, 32'h3);
        key = 2'b10;
        idle(2);
        cyc(1'b0, BASE + 32'h8, 1'b0, 32'h0);
        rd(BASE + 32'h8, v);
        chk("t6_key_rst", v, 32'h0);
        rd(BASE + 32'hC, v);
        chk("t6_edge_rst", v, 32'h0);
        key = 2'b11;
        idle(2);
        key = 2'b10;
        idle(5);
        rd(BASE + 32'h8, v);
        chk("t6_key_5clk", v, 32'h0);
        idle(1);
        rd(BASE + 32'h8, v);
        chk("t6_key_6clk", v, 32'h1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) key[$urandom_range(0, 1)] ^= 1'b1;
            sw = 4'($urandom);
            r  = ($urandom_range(0, 63) != 0);
            a  = ($urandom_range(0, 3) != 0) ? BASE + 32'($urandom_range(0, 15)) : 32'($urandom);
            cyc(r, a, 1'($urandom), 32'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
